// File: rtl/s181703_gcd_pkg.sv
// Shared types and width derivations for the parametrised binary-GCD engine.
// Optional cycle counter is enabled by defining S181703_GCD_CYCLES_EN.
package s181703_gcd_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STRIP  = 2'd1,
    REDUCE = 2'd2,
    DONE   = 2'd3
  } gcd_state_e;

  // Per-cycle datapath actions; at most one is asserted in any cycle.
  typedef struct packed {
    logic load;
    logic strip;
    logic shr_a;
    logic shr_b;
    logic sub_ab;
    logic sub_ba;
  } gcd_ctrl_t;

  // Worst-case number of edges from an accepted start until done rises.
  function automatic int gcd_bound(input int width);
    return 4 * width + 2;
  endfunction

  function automatic int cw_of(input int width);
    return $clog2(gcd_bound(width) + 1);
  endfunction

  function automatic int kw_of(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/s181703_gcdn_if.sv
// Request/result handshake bundle between the operand source and the GCD engine.
// The cycles signal exists only when S181703_GCD_CYCLES_EN is defined.
interface s181703_gcdn_if
  import s181703_gcd_pkg::*;
#(
  parameter int WIDTH = 32
);

  logic             start;
  logic [WIDTH-1:0] x_in;
  logic [WIDTH-1:0] y_in;
  logic             gcd_done;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] gcd_out;
  logic             zero_err;
`ifdef S181703_GCD_CYCLES_EN
  localparam int CW = cw_of(WIDTH);
  logic [CW-1:0]    cycles;
`endif

  modport master (
    output start, x_in, y_in, gcd_done,
    input  busy, done, gcd_out, zero_err
`ifdef S181703_GCD_CYCLES_EN
    , input cycles
`endif
  );

  modport slave (
    input  start, x_in, y_in, gcd_done,
    output busy, done, gcd_out, zero_err
`ifdef S181703_GCD_CYCLES_EN
    , output cycles
`endif
  );

endinterface

// File: rtl/s181703_gcdn_dp.sv
// Stein-algorithm datapath: a/b operand registers, shared power-of-two count k,
// and the compare/subtract/shift network steered by the FSM's control word.
module s181703_gcdn_dp
  import s181703_gcd_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             wireclk,
  input  logic             resetn,
  input  gcd_ctrl_t        i_ctrl,
  input  logic [WIDTH-1:0] i_x,
  input  logic [WIDTH-1:0] i_y,
  output logic             o_a_even,
  output logic             o_b_even,
  output logic             o_a_eq_b,
  output logic             o_a_gt_b,
  output logic [WIDTH-1:0] o_result
);

  localparam int KW = kw_of(WIDTH);

  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [KW-1:0]    r_k;

  // NOTE: state registers use non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge wireclk or negedge resetn) begin
    if (!resetn) begin
      r_a <= '0;
      r_b <= '0;
      r_k <= '0;
    end else if (i_ctrl.load) begin
      r_a <= i_x;
      r_b <= i_y;
      r_k <= '0;
    end else if (i_ctrl.strip) begin
      r_a <= r_a >> 1;
      r_b <= r_b >> 1;
      r_k <= r_k + KW'(1);
    end else if (i_ctrl.shr_a) begin
      r_a <= r_a >> 1;
    end else if (i_ctrl.shr_b) begin
      r_b <= r_b >> 1;
    end else if (i_ctrl.sub_ab) begin
      r_a <= r_a - r_b;
    end else if (i_ctrl.sub_ba) begin
      r_b <= r_b - r_a;
    end
  end

  assign o_a_even = ~r_a[0];
  assign o_b_even = ~r_b[0];
  assign o_a_eq_b = (r_a == r_b);
  assign o_a_gt_b = (r_a > r_b);
  // The true gcd fits in WIDTH bits, so restoring the common factor cannot overflow.
  assign o_result = r_a << r_k;

endmodule

// File: rtl/s181703_gcdn.sv
// Top of the WIDTH-bit binary GCD engine: FSM, start/done/gcd_done handshake,
// registered result flags; S181703_GCD_CYCLES_EN adds an iteration counter.
module s181703_gcdn
  import s181703_gcd_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CW    = cw_of(WIDTH)
) (
  input  logic         wireclk,
  input  logic         resetn,
  s181703_gcdn_if.slave bus
);

  if (WIDTH < 2) begin : g_bad_width
    $error("s181703_gcdn: WIDTH must be at least 2");
  end
  if (CW != cw_of(WIDTH)) begin : g_bad_cw
    $error("s181703_gcdn: CW is derived from WIDTH and must not be overridden");
  end

  gcd_state_e       r_state;
  gcd_state_e       w_state_nx;
  gcd_ctrl_t        w_ctrl;
  logic             w_accept;
  logic             w_res_ld;
  logic [WIDTH-1:0] w_res_val;
  logic             w_zero_nx;

  logic             w_a_even;
  logic             w_b_even;
  logic             w_a_eq_b;
  logic             w_a_gt_b;
  logic [WIDTH-1:0] w_result;

  logic             r_done;
  logic [WIDTH-1:0] r_gcd_out;
  logic             r_zero_err;

  s181703_gcdn_dp #(
    .WIDTH (WIDTH)
  ) u_dp (
    .wireclk  (wireclk),
    .resetn   (resetn),
    .i_ctrl   (w_ctrl),
    .i_x      (bus.x_in),
    .i_y      (bus.y_in),
    .o_a_even (w_a_even),
    .o_b_even (w_b_even),
    .o_a_eq_b (w_a_eq_b),
    .o_a_gt_b (w_a_gt_b),
    .o_result (w_result)
  );

  always_ff @(posedge wireclk or negedge resetn) begin
    if (!resetn) r_state <= IDLE;
    else         r_state <= w_state_nx;
  end

  // NOTE: every signal written here gets a default first, so no path through
  // the case statement can leave one unassigned and infer a latch.
  always_comb begin
    w_state_nx = r_state;
    w_ctrl     = '0;
    w_accept   = 1'b0;
    w_res_ld   = 1'b0;
    w_res_val  = '0;
    w_zero_nx  = 1'b0;
    case (r_state)
      IDLE: begin
        if (bus.start) begin
          w_accept    = 1'b1;
          w_ctrl.load = 1'b1;
          if (bus.x_in == '0 || bus.y_in == '0) begin
            w_state_nx = DONE;
            w_res_ld   = 1'b1;
            w_res_val  = bus.x_in | bus.y_in;
            w_zero_nx  = (bus.x_in == '0) && (bus.y_in == '0);
          end else begin
            w_state_nx = STRIP;
          end
        end
      end
      STRIP: begin
        if (w_a_even && w_b_even) w_ctrl.strip = 1'b1;
        else                      w_state_nx   = REDUCE;
      end
      REDUCE: begin
        if (w_a_even)      w_ctrl.shr_a = 1'b1;
        else if (w_b_even) w_ctrl.shr_b = 1'b1;
        else if (w_a_eq_b) begin
          w_state_nx = DONE;
          w_res_ld   = 1'b1;
          w_res_val  = w_result;
        end
        else if (w_a_gt_b) w_ctrl.sub_ab = 1'b1;
        else               w_ctrl.sub_ba = 1'b1;
      end
      DONE: begin
        if (bus.gcd_done) w_state_nx = IDLE;
      end
      default: w_state_nx = IDLE;
    endcase
  end

  // Result and flags change only on the DONE entry edge; done tracks the state.
  always_ff @(posedge wireclk or negedge resetn) begin
    if (!resetn) begin
      r_done     <= 1'b0;
      r_gcd_out  <= '0;
      r_zero_err <= 1'b0;
    end else begin
      r_done <= (w_state_nx == DONE);
      if (w_res_ld) begin
        r_gcd_out  <= w_res_val;
        r_zero_err <= w_zero_nx;
      end
    end
  end

  assign bus.busy     = (r_state != IDLE);
  assign bus.done     = r_done;
  assign bus.gcd_out  = r_gcd_out;
  assign bus.zero_err = r_zero_err;

`ifdef S181703_GCD_CYCLES_EN
  logic [CW-1:0] r_cycles;

  always_ff @(posedge wireclk or negedge resetn) begin
    if (!resetn)                                  r_cycles <= '0;
    else if (w_accept)                            r_cycles <= '0;
    else if (r_state == STRIP || r_state == REDUCE) r_cycles <= r_cycles + CW'(1);
  end

  assign bus.cycles = r_cycles;
`else
  logic w_unused_accept;
  assign w_unused_accept = w_accept;
`endif

endmodule

// File: tb/tb_s181703_gcdn.sv
// Directed bench for s181703_gcdn at WIDTH=32 and WIDTH=8, plus a batch of
// random operand pairs checked against a Euclid reference.
module tb_s181703_gcdn;

  localparam int BOUND32 = 4 * 32 + 2;
  localparam int BOUND8  = 4 * 8 + 2;

  logic clk;
  logic resetn;
  int   n_checks = 0;
  int   n_errors = 0;

  s181703_gcdn_if #(.WIDTH(32)) bus32 ();
  s181703_gcdn_if #(.WIDTH(8))  bus8 ();

  s181703_gcdn #(.WIDTH(32)) dut32 (.wireclk(clk), .resetn(resetn), .bus(bus32.slave));
  s181703_gcdn #(.WIDTH(8))  dut8  (.wireclk(clk), .resetn(resetn), .bus(bus8.slave));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] ref_gcd(input logic [31:0] a, input logic [31:0] b);
    logic [31:0] t;
    while (b != 0) begin
      t = a % b;
      a = b;
      b = t;
    end
    return a;
  endfunction

  task automatic start32(input logic [31:0] x, input logic [31:0] y);
    bus32.x_in  = x;
    bus32.y_in  = y;
    bus32.start = 1'b1;
    tick();
    bus32.start = 1'b0;
  endtask

  task automatic wait32(input string tag);
    int n = 0;
    while (!bus32.done && n < BOUND32) begin
      tick();
      n++;
    end
    check({tag, "_done"}, bus32.done, 1);
  endtask

  task automatic ack32(input string tag);
    bus32.gcd_done = 1'b1;
    tick();
    bus32.gcd_done = 1'b0;
    check({tag, "_ack_done"}, bus32.done, 0);
    check({tag, "_ack_busy"}, bus32.busy, 0);
  endtask

  task automatic run32(input string tag, input logic [31:0] x, input logic [31:0] y,
                       input logic [31:0] exp, input logic zexp);
    start32(x, y);
    wait32(tag);
    check({tag, "_gcd"}, bus32.gcd_out, exp);
    check({tag, "_zerr"}, bus32.zero_err, zexp);
    ack32(tag);
  endtask

  // Operand inputs are scrambled every cycle after acceptance.
  task automatic run8(input string tag, input logic [7:0] x, input logic [7:0] y,
                      input logic [7:0] exp);
    int n = 0;
    bus8.x_in  = x;
    bus8.y_in  = y;
    bus8.start = 1'b1;
    tick();
    bus8.start = 1'b0;
    while (!bus8.done && n < BOUND8) begin
      bus8.x_in = 8'($urandom);
      bus8.y_in = 8'($urandom);
      tick();
      n++;
    end
    check({tag, "_done"}, bus8.done, 1);
    check({tag, "_gcd"}, bus8.gcd_out, exp);
    bus8.gcd_done = 1'b1;
    tick();
    bus8.gcd_done = 1'b0;
    check({tag, "_ack_done"}, bus8.done, 0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] x, y;

    resetn = 1'b0;
    bus32.start = 1'b0; bus32.gcd_done = 1'b0; bus32.x_in = '0; bus32.y_in = '0;
    bus8.start  = 1'b0; bus8.gcd_done  = 1'b0; bus8.x_in  = '0; bus8.y_in  = '0;
    #12;
    check("rst_busy", bus32.busy, 0);
    check("rst_done", bus32.done, 0);
    check("rst_gcd", bus32.gcd_out, 0);
    check("rst_zerr", bus32.zero_err, 0);
    check("rst8_busy", bus8.busy, 0);
`ifdef S181703_GCD_CYCLES_EN
    check("rst_cycles", bus32.cycles, 0);
`endif
    resetn = 1'b1;
    tick();

    // (48,18): busy right after acceptance, result 6.
    start32(48, 18);
    check("g48_busy", bus32.busy, 1);
    check("g48_done_early", bus32.done, 0);
    wait32("g48");
    check("g48_gcd", bus32.gcd_out, 6);
    check("g48_zerr", bus32.zero_err, 0);
`ifdef S181703_GCD_CYCLES_EN
    check("g48_cycles", bus32.cycles, 8);
`endif
    ack32("g48");

    // Zero-operand requests finish on the accepting edge.
    start32(0, 35);
    check("z35_done", bus32.done, 1);
    check("z35_gcd", bus32.gcd_out, 35);
    check("z35_zerr", bus32.zero_err, 0);
`ifdef S181703_GCD_CYCLES_EN
    check("z35_cycles", bus32.cycles, 0);
`endif
    ack32("z35");
    start32(0, 0);
    check("z00_done", bus32.done, 1);
    check("z00_gcd", bus32.gcd_out, 0);
    check("z00_zerr", bus32.zero_err, 1);
`ifdef S181703_GCD_CYCLES_EN
    check("z00_cycles", bus32.cycles, 0);
`endif
    ack32("z00");

    run32("pow2", 32'h8000_0000, 32'h4000_0000, 32'h4000_0000, 1'b0);
    run32("prime", 17, 13, 1, 1'b0);
    run32("ones", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);

    run8("w8_255", 8'd255, 8'd85, 8'd85);
    run8("w8_128", 8'd128, 8'd96, 8'd32);

    // Asynchronous reset during REDUCE abandons the computation.
    start32(48, 18);
    tick();
    tick();
    check("mid_busy", bus32.busy, 1);
    #2 resetn = 1'b0;
    #1;
    check("mid_rst_busy", bus32.busy, 0);
    check("mid_rst_done", bus32.done, 0);
    check("mid_rst_gcd", bus32.gcd_out, 0);
    check("mid_rst_zerr", bus32.zero_err, 0);
    #3 resetn = 1'b1;
    tick();
    run32("after_rst", 21, 14, 7, 1'b0);

    // start together with gcd_done in DONE is ignored; held start is taken next edge.
    start32(17, 13);
    wait32("hold");
    check("hold_gcd", bus32.gcd_out, 1);
    bus32.x_in     = 21;
    bus32.y_in     = 14;
    bus32.start    = 1'b1;
    bus32.gcd_done = 1'b1;
    tick();
    bus32.gcd_done = 1'b0;
    check("hold_m_done", bus32.done, 0);
    check("hold_m_busy", bus32.busy, 0);
    tick();
    bus32.start = 1'b0;
    check("hold_m1_busy", bus32.busy, 1);
    wait32("hold2");
    check("hold2_gcd", bus32.gcd_out, 7);
    ack32("hold2");

    // gcd_done while computing is ignored.
    start32(96, 60);
    bus32.gcd_done = 1'b1;
    tick();
    bus32.gcd_done = 1'b0;
    check("early_ack_busy", bus32.busy, 1);
    wait32("early_ack");
    check("early_ack_gcd", bus32.gcd_out, 12);
    ack32("early_ack");

    for (int i = 0; i < 300; i++) begin
      if (i % 2 == 0) begin
        x = $urandom;
        y = $urandom;
      end else begin
        int f;
        f = $urandom_range(1, 4096);
        x = ($urandom & 32'h000F_FFFF) * f[31:0];
        y = ($urandom & 32'h000F_FFFF) * f[31:0];
        if (i % 7 == 0) x = 0;
      end
      run32("rand", x, y, ref_gcd(x, y), (x == 0) && (y == 0));
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
